// File: rtl/seq_det_pkg.sv
// Shared encodings for the parametrised serial sequence detector:
// fill-level states and the overlap mode constants.
package seq_det_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Width-parametrised saturating up-counter with synchronous reset and clear.
// Clear wins over increment; the count holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial N-bit pattern detector with loadable pattern, selectable overlap mode,
// registered match pulse, saturating match counter and an armed flag.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int N     = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic [N-1:0]     pattern,
    input  logic             load,
    input  logic             overlap_en,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed,
    output state_t           state
);

    localparam int            FW   = $clog2(N + 1);
    localparam logic [FW-1:0] FULL = FW'(N);

    logic [N-1:0]  pat_q;
    logic          mode_q;
    logic [N-1:0]  hist_q, hist_d, shifted;
    logic [FW-1:0] fill_q, fill_d, fill_inc;
    state_t        state_q, state_d;
    logic          match_q, hit;
    logic          armed_q;

    assign shifted  = {hist_q[N-2:0], din};
    assign fill_inc = (fill_q == FULL) ? FULL : fill_q + 1'b1;

    // Next-state: load clears progress; a valid bit shifts in and may complete a match.
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        hit     = 1'b0;
        if (load) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = EMPTY;
        end else if (din_valid) begin
            hist_d = shifted;
            hit    = (fill_inc == FULL) && (shifted == pat_q);
            fill_d = (hit && (mode_q == MODE_NONOVL)) ? '0 : fill_inc;
            if (fill_d == '0) begin
                state_d = EMPTY;
            end else if (fill_d == FULL) begin
                state_d = ARMED;
            end else begin
                state_d = FILLING;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= '0;
            mode_q  <= MODE_OVL;
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= EMPTY;
            match_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            if (load) begin
                pat_q  <= pattern;
                mode_q <= overlap_en;
            end
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            match_q <= hit;
            armed_q <= (fill_d == FULL);
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .inc (hit),
        .cnt (match_cnt)
    );

    assign match = match_q;
    assign armed = armed_q;
    assign state = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three instances (N=3, N=4, N=2/CNT_W=2) driven
// cycle by cycle; expected {match, armed, match_cnt} entries queue per cycle.
module tb_seq_detector_param;
    import seq_det_pkg::*;

    localparam int EW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N=3, CNT_W=8
    logic       a_rst = 1'b1, a_din = 1'b0, a_valid = 1'b0, a_load = 1'b0, a_ovl = 1'b0;
    logic [2:0] a_pat = '0;
    logic       a_match, a_armed;
    logic [7:0] a_cnt;
    state_t     a_state;
    // Instance B: N=4, CNT_W=8
    logic       b_rst = 1'b1, b_din = 1'b0, b_valid = 1'b0, b_load = 1'b0, b_ovl = 1'b0;
    logic [3:0] b_pat = '0;
    logic       b_match, b_armed;
    logic [7:0] b_cnt;
    state_t     b_state;
    // Instance C: N=2, CNT_W=2
    logic       c_rst = 1'b1, c_din = 1'b0, c_valid = 1'b0, c_load = 1'b0, c_ovl = 1'b0;
    logic [1:0] c_pat = '0;
    logic       c_match, c_armed;
    logic [1:0] c_cnt;
    state_t     c_state;

    seq_detector_param #(.N(3), .CNT_W(8)) dut_a (
        .clk(clk), .rst(a_rst), .din(a_din), .din_valid(a_valid), .pattern(a_pat),
        .load(a_load), .overlap_en(a_ovl), .match(a_match), .match_cnt(a_cnt),
        .armed(a_armed), .state(a_state));
    seq_detector_param #(.N(4), .CNT_W(8)) dut_b (
        .clk(clk), .rst(b_rst), .din(b_din), .din_valid(b_valid), .pattern(b_pat),
        .load(b_load), .overlap_en(b_ovl), .match(b_match), .match_cnt(b_cnt),
        .armed(b_armed), .state(b_state));
    seq_detector_param #(.N(2), .CNT_W(2)) dut_c (
        .clk(clk), .rst(c_rst), .din(c_din), .din_valid(c_valid), .pattern(c_pat),
        .load(c_load), .overlap_en(c_ovl), .match(c_match), .match_cnt(c_cnt),
        .armed(c_armed), .state(c_state));

    logic [EW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    function automatic logic [EW-1:0] e(input logic m, input logic a, input int c);
        return {m, a, 8'(c)};
    endfunction

    // One clock of instance A; expected result is queued then compared after the edge.
    task automatic cyc_a(input logic r, input logic l, input logic v, input logic d,
                         input logic [2:0] p, input logic o, input logic [EW-1:0] ex,
                         input string name);
        logic [EW-1:0] got, want;
        exp_q.push_back(ex);
        a_rst = r; a_load = l; a_valid = v; a_din = d; a_pat = p; a_ovl = o;
        @(posedge clk); #1;
        got  = {a_match, a_armed, a_cnt};
        want = exp_q.pop_front();
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got m=%b a=%b cnt=%0d, want m=%b a=%b cnt=%0d",
                     name, got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
        end
    endtask

    task automatic cyc_b(input logic l, input logic v, input logic d, input logic [3:0] p,
                         input logic o, input logic [EW-1:0] ex, input string name);
        logic [EW-1:0] got, want;
        exp_q.push_back(ex);
        b_rst = 1'b0; b_load = l; b_valid = v; b_din = d; b_pat = p; b_ovl = o;
        @(posedge clk); #1;
        got  = {b_match, b_armed, b_cnt};
        want = exp_q.pop_front();
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got m=%b a=%b cnt=%0d, want m=%b a=%b cnt=%0d",
                     name, got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
        end
    endtask

    task automatic cyc_c(input logic l, input logic v, input logic d, input logic [1:0] p,
                         input logic o, input logic [EW-1:0] ex, input string name);
        logic [EW-1:0] got, want;
        exp_q.push_back(ex);
        c_rst = 1'b0; c_load = l; c_valid = v; c_din = d; c_pat = p; c_ovl = o;
        @(posedge clk); #1;
        got  = {c_match, c_armed, 6'd0, c_cnt};
        want = exp_q.pop_front();
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got m=%b a=%b cnt=%0d, want m=%b a=%b cnt=%0d",
                     name, got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
        end
    endtask

    task automatic test_reset();
        cyc_a(1, 1, 1, 1, 3'b111, 0, e(0, 0, 0), "reset_a");
        tests++;
        if (a_state !== EMPTY) begin
            fails++;
            $display("FAIL reset_state: got %0d, want %0d", a_state, EMPTY);
        end
        // Reset captures pattern 000 in overlapping mode.
        cyc_a(0, 0, 1, 0, 3'b111, 0, e(0, 0, 0), "rstpat_b1");
        cyc_a(0, 0, 1, 0, 3'b111, 0, e(0, 0, 0), "rstpat_b2");
        tests++;
        if (a_state !== FILLING) begin
            fails++;
            $display("FAIL filling_state: got %0d, want %0d", a_state, FILLING);
        end
        cyc_a(0, 0, 1, 0, 3'b111, 0, e(1, 1, 1), "rstpat_b3");
        cyc_a(0, 0, 1, 0, 3'b111, 0, e(1, 1, 2), "rstpat_b4_ovl");
        tests++;
        if (a_state !== ARMED) begin
            fails++;
            $display("FAIL armed_state: got %0d, want %0d", a_state, ARMED);
        end
    endtask

    task automatic test_overlap();
        cyc_a(0, 1, 1, 1, 3'b011, 1, e(0, 0, 0), "ovl_load");
        // Pattern/mode ports wander afterwards and must be ignored.
        cyc_a(0, 0, 1, 0, 3'b101, 0, e(0, 0, 0), "ovl_b1");
        cyc_a(0, 0, 1, 1, 3'b101, 0, e(0, 0, 0), "ovl_b2");
        cyc_a(0, 0, 1, 1, 3'b101, 0, e(1, 1, 1), "ovl_b3");
        cyc_a(0, 0, 1, 1, 3'b000, 0, e(0, 1, 1), "ovl_b4");
        cyc_a(0, 0, 1, 0, 3'b000, 0, e(0, 1, 1), "ovl_b5");
        cyc_a(0, 0, 1, 1, 3'b110, 0, e(0, 1, 1), "ovl_b6");
        cyc_a(0, 0, 1, 1, 3'b110, 0, e(1, 1, 2), "ovl_b7");
        cyc_a(0, 0, 0, 1, 3'b110, 0, e(0, 1, 2), "ovl_idle");
    endtask

    task automatic test_gaps();
        logic [2:0] bits;
        bits = 3'b011;
        cyc_a(0, 1, 0, 0, 3'b011, 1, e(0, 0, 0), "gap_load");
        for (int i = 2; i >= 0; i--) begin
            cyc_a(0, 0, 1, bits[i], 3'b011, 1, e(i == 0, i == 0, i == 0 ? 1 : 0), "gap_bit");
            for (int g = 0; g < 2; g++)
                cyc_a(0, 0, 0, ~bits[i], 3'b011, 1, e(0, i == 0, i == 0 ? 1 : 0), "gap_idle");
        end
    endtask

    task automatic test_load_midseq();
        cyc_a(0, 1, 0, 0, 3'b011, 1, e(0, 0, 0), "ldm_load1");
        cyc_a(0, 0, 1, 0, 3'b011, 1, e(0, 0, 0), "ldm_b1");
        cyc_a(0, 0, 1, 1, 3'b011, 1, e(0, 0, 0), "ldm_b2");
        cyc_a(0, 1, 1, 1, 3'b101, 1, e(0, 0, 0), "ldm_load2");
        cyc_a(0, 0, 1, 1, 3'b000, 0, e(0, 0, 0), "ldm_n1");
        cyc_a(0, 0, 1, 0, 3'b000, 0, e(0, 0, 0), "ldm_n2");
        cyc_a(0, 0, 1, 1, 3'b000, 0, e(1, 1, 1), "ldm_n3");
    endtask

    task automatic test_reset_midseq();
        cyc_a(0, 1, 0, 0, 3'b011, 1, e(0, 0, 0), "rsm_load");
        cyc_a(0, 0, 1, 0, 3'b011, 1, e(0, 0, 0), "rsm_b1");
        cyc_a(0, 0, 1, 1, 3'b011, 1, e(0, 0, 0), "rsm_b2");
        cyc_a(1, 1, 1, 1, 3'b011, 1, e(0, 0, 0), "rsm_rst");
        cyc_a(0, 0, 1, 1, 3'b011, 1, e(0, 0, 0), "rsm_b3");
    endtask

    task automatic test_modes_n4();
        logic [5:0] bits;
        bits = 6'b101010;
        b_rst = 1'b1;
        @(posedge clk); #1;
        cyc_b(1, 0, 0, 4'b1010, 1, e(0, 0, 0), "n4_ovl_load");
        for (int i = 5; i >= 0; i--)
            cyc_b(0, 1, bits[i], 4'b0000, 0,
                  e(i == 2 || i == 0, i <= 2, i == 0 ? 2 : (i <= 2 ? 1 : 0)), "n4_ovl_bit");
        cyc_b(1, 0, 0, 4'b1010, 0, e(0, 0, 0), "n4_novl_load");
        for (int i = 5; i >= 0; i--)
            cyc_b(0, 1, bits[i], 4'b1111, 1, e(i == 2, 0, i <= 2 ? 1 : 0), "n4_novl_bit");
    endtask

    task automatic test_saturate();
        c_rst = 1'b1;
        @(posedge clk); #1;
        cyc_c(1, 0, 0, 2'b11, 1, e(0, 0, 0), "sat_load");
        for (int i = 1; i <= 6; i++)
            cyc_c(0, 1, 1, 2'b00, 0, e(i >= 2, i >= 2, (i - 1 > 3) ? 3 : i - 1), "sat_bit");
        cyc_c(1, 0, 0, 2'b11, 0, e(0, 0, 0), "c_novl_load");
        for (int i = 1; i <= 4; i++)
            cyc_c(0, 1, 1, 2'b00, 1, e(i % 2 == 0, 0, i / 2), "c_novl_bit");
    endtask

    task automatic test_random();
        logic [2:0] pat, mh, sh;
        logic       mode, v, d, m;
        int         mf, mf_inc, mc;
        pat = 3'($urandom_range(0, 7));
        mode = 1'($urandom_range(0, 1));
        mh = '0; mf = 0; mc = 0;
        cyc_a(0, 1, 0, 0, pat, mode, e(0, 0, 0), "rnd_load");
        for (int i = 0; i < 200; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            d = 1'($urandom_range(0, 1));
            m = 1'b0;
            if (v) begin
                sh = {mh[1:0], d};
                mf_inc = (mf == 3) ? 3 : mf + 1;
                m = (mf_inc == 3) && (sh == pat);
                mh = sh;
                mf = (m && !mode) ? 0 : mf_inc;
                if (m) mc++;
            end
            cyc_a(0, 0, v, d, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  e(m, mf == 3, mc), "rnd_step");
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_gaps();
        test_load_midseq();
        test_reset_midseq();
        test_modes_n4();
        test_saturate();
        test_random();
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL queue_drain: got %0d left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter N, default 3: pattern length in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 8: width of the match counter, legal range 1..32.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port din, input, 1: serial data bit.
REQ-006 Port din_valid, input, 1: din is sampled only when this is high.
REQ-007 Port pattern, input, N: target sequence; pattern[N-1] is the first bit expected, pattern[0] the last.
REQ-008 Port load, input, 1: one-cycle strobe that captures pattern and overlap_en.
REQ-009 Port overlap_en, input, 1: 1 selects overlapping detection, 0 selects non-overlapping detection.
REQ-010 Port match, output, 1: registered one-cycle pulse marking a completed pattern.
REQ-011 Port match_cnt, output, CNT_W: saturating count of matches since reset or load.
REQ-012 Port armed, output, 1: high when the history holds at least N valid bits.

Function
REQ-013 Captured pattern and mode registers only SHALL change on reset or load; in-flight changes on the pattern and overlap_en ports SHALL have no effect.
REQ-014 On each edge with din_valid=1 and load=0, din SHALL shift into an N-bit history at the LSB, and the fill count SHALL increment, saturating at N.
REQ-015 A match SHALL occur on that edge when the fill count after the shift is N and the history after the shift equals the captured pattern.
REQ-016 match SHALL be high for exactly the one cycle following the edge that sampled the final pattern bit, and low in all other cycles.
REQ-017 match SHALL be low in any cycle that follows an edge with din_valid=0; gaps in din_valid SHALL NOT break a partial sequence.
REQ-018 In overlapping mode, after a match the fill count SHALL stay at N, so suffix bits count toward the next match.
REQ-019 In non-overlapping mode, after a match the fill count SHALL clear to 0, so the next match needs N fresh bits.
REQ-020 On each match, match_cnt SHALL increment by 1 and saturate at 2^CNT_W-1 without wrapping.
REQ-021 armed SHALL be a registered output equal to (fill count == N).
REQ-022 load SHALL take priority over din_valid: it clears the history, fill count, match_cnt and match on the same edge, and din is not sampled on that edge.
REQ-023 The block SHALL have three states: EMPTY (fill 0), FILLING (0 < fill < N) and ARMED (fill = N).
REQ-024 State transitions: EMPTY->FILLING on a valid bit; FILLING->ARMED when fill reaches N; ARMED->EMPTY on a match in non-overlapping mode; any state->EMPTY on load or rst.

Reset
REQ-025 While rst=1 at a rising edge, the following SHALL be cleared: history=0, fill=0, match=0, match_cnt=0, armed=0, captured pattern=0, captured mode=overlapping.
REQ-026 rst SHALL take priority over load and din_valid.
REQ-027 Reset asserted mid-sequence SHALL discard all partial progress.

Structure
REQ-028 Package seq_det_pkg SHALL hold the state encodings (EMPTY, FILLING, ARMED) and the mode constants (MODE_NONOVL=0, MODE_OVL=1).
REQ-029 The saturating counter SHALL be a separate sub-module, sat_counter, parametrised by width, with inc and clr inputs.
REQ-030 The fill count SHALL be clog2(N+1) bits wide.

Verification
REQ-031 N=3, load pattern 011 with overlap_en=1, then bits 0,1,1,1,0,1,1 -> match pulses after the 3rd and 7th bits; match_cnt=2.
REQ-032 N=4, pattern 1010, bits 1,0,1,0,1,0 -> overlapping mode: matches after bits 4 and 6 (cnt=2); non-overlapping mode: match after bit 4 only (cnt=1).
REQ-033 N=3, pattern 011, bits 0,1,1 with din_valid low for 2 cycles between each bit -> exactly one match pulse; match stays low during the gaps.
REQ-034 CNT_W=2, pattern 11, overlapping mode, six consecutive 1s -> match_cnt reaches 3 and holds; match still pulses every cycle from the 2nd bit on.
REQ-035 N=3, pattern 011, bits 0,1 then load (new pattern 101) with din_valid=1 and din=1 -> no match; armed=0; match_cnt=0; the next bits 1,0,1 produce one match.
REQ-036 N=3, pattern 011, bits 0,1 then rst for one cycle then bit 1 -> no match; all outputs are 0 after the reset edge.
